// File: rtl/aes_arb_pkg.sv
// Shared types for the AES_128 core arbiter.
// Optional build macro used by the arbiter: AES_ARB_PRIO0_EN.
package aes_arb_pkg;

    localparam int AES_BLK_W = 128;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } arb_state_t;

    typedef logic [AES_BLK_W-1:0] aes_blk_t;

endpackage

// File: rtl/aes_rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr,
// wrapping modulo N. Produces a one-hot grant, its index and an any flag.
module aes_rr_pick #(
    parameter int N  = 4,
    parameter int PW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [PW-1:0] idx,
    output logic          any
);

    // (p + k) mod N without a divider; p < N and k < N keep the sum below 2N
    function automatic logic [PW-1:0] wrap_add(input logic [PW-1:0] p, input int k);
        int s;
        s = int'(p) + k;
        if (s >= N) s = s - N;
        return PW'(s);
    endfunction

    // Scan from farthest to nearest so the nearest valid requester wins
    always_comb begin
        gnt = '0;
        idx = '0;
        any = 1'b0;
        for (int k = N - 1; k >= 0; k--) begin
            if (req[wrap_add(ptr, k)]) begin
                gnt                 = '0;
                gnt[wrap_add(ptr, k)] = 1'b1;
                idx                 = wrap_add(ptr, k);
                any                 = 1'b1;
            end
        end
    end

endmodule

// File: rtl/aes_core_arbiter.sv
// Shares one combinational AES_128 core among N_REQ requesters.
// One operation in flight; operands registered in front of the core and
// core_out sampled CORE_LAT edges after the accept edge.
// Build macro AES_ARB_PRIO0_EN: requester 0 gets strict priority and the
// round-robin rotation covers only requesters 1..N_REQ-1.
module aes_core_arbiter
    import aes_arb_pkg::*;
#(
    parameter int N_REQ    = 4,
    parameter int CORE_LAT = 1,
    parameter int ID_W     = $clog2(N_REQ)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [N_REQ-1:0]           req_valid,
    output logic [N_REQ-1:0]           req_ready,
    input  logic [N_REQ*AES_BLK_W-1:0] req_key,
    input  logic [N_REQ*AES_BLK_W-1:0] req_state,
    output aes_blk_t                   core_key,
    output aes_blk_t                   core_state,
    input  aes_blk_t                   core_out,
    output logic                       rsp_valid,
    input  logic                       rsp_ready,
    output aes_blk_t                   rsp_data,
    output logic [ID_W-1:0]            rsp_id,
    output logic                       busy
);

    localparam int                CNT_W    = $clog2(CORE_LAT + 1);
    localparam logic [CNT_W-1:0]  LAT_INIT = CNT_W'(CORE_LAT);

    arb_state_t       state;
    logic [ID_W-1:0]  ptr;
    logic [ID_W-1:0]  lat_id;
    logic [CNT_W-1:0] cnt;

    logic [N_REQ-1:0] pick_req;
    logic [N_REQ-1:0] pick_gnt;
    logic [ID_W-1:0]  pick_idx;
    logic             pick_any;

    logic [N_REQ-1:0] grant;
    logic [ID_W-1:0]  grant_idx;
    logic             grant_any;

    aes_blk_t         sel_key;
    aes_blk_t         sel_state;

    // Rotation pointer after serving id; under strict priority slot 0 is never
    // part of the rotation, so the pointer steps over it.
    function automatic logic [ID_W-1:0] next_ptr(input logic [ID_W-1:0] id);
        logic [ID_W-1:0] n;
        n = (int'(id) == N_REQ - 1) ? '0 : id + ID_W'(1);
`ifdef AES_ARB_PRIO0_EN
        if (n == '0) n = ID_W'(1);
`endif
        return n;
    endfunction

    aes_rr_pick #(
        .N  (N_REQ),
        .PW (ID_W)
    ) u_pick (
        .req (pick_req),
        .ptr (ptr),
        .gnt (pick_gnt),
        .idx (pick_idx),
        .any (pick_any)
    );

`ifdef AES_ARB_PRIO0_EN
    assign pick_req = {req_valid[N_REQ-1:1], 1'b0};

    // Requester 0 overrides the rotation whenever it asks
    always_comb begin
        if (req_valid[0]) begin
            grant     = N_REQ'(1);
            grant_idx = '0;
            grant_any = 1'b1;
        end else begin
            grant     = pick_gnt;
            grant_idx = pick_idx;
            grant_any = pick_any;
        end
    end
`else
    assign pick_req = req_valid;

    // Plain round-robin over every requester
    always_comb begin
        grant     = pick_gnt;
        grant_idx = pick_idx;
        grant_any = pick_any;
    end
`endif

    // Operand mux for the granted requester
    assign sel_key   = req_key[int'(grant_idx)*AES_BLK_W +: AES_BLK_W];
    assign sel_state = req_state[int'(grant_idx)*AES_BLK_W +: AES_BLK_W];

    // Accept strobe only while idle and not being reset
    assign req_ready = (state == IDLE && !rst) ? grant : '0;

    // Arbitration FSM, operand registers and response holding registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            ptr        <= '0;
            lat_id     <= '0;
            cnt        <= '0;
            core_key   <= '0;
            core_state <= '0;
            rsp_data   <= '0;
            rsp_id     <= '0;
            rsp_valid  <= 1'b0;
            busy       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_any) begin
                        core_key   <= sel_key;
                        core_state <= sel_state;
                        lat_id     <= grant_idx;
                        cnt        <= LAT_INIT;
                        busy       <= 1'b1;
                        state      <= WAIT;
                    end
                end
                WAIT: begin
                    cnt <= cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1)) begin
                        rsp_data  <= core_out;
                        rsp_id    <= lat_id;
                        rsp_valid <= 1'b1;
                        state     <= RESP;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        ptr       <= next_ptr(lat_id);
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    rsp_valid <= 1'b0;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_aes_core_arbiter.sv
// Bench for aes_core_arbiter: a real AES-128 reference drives core_out (with
// a settle window), a transaction-level model predicts every output each
// cycle, and directed scenarios pin grant order, latency and known vectors.
module tb_aes_core_arbiter;

    localparam int N   = 4;
    localparam int LAT = 2;
    localparam int IW  = 2;
`ifdef AES_ARB_PRIO0_EN
    localparam bit PRIO0 = 1'b1;
`else
    localparam bit PRIO0 = 1'b0;
`endif

    localparam logic [127:0] K1  = 128'he4dc18adf3d05ec9e4dcc41acb990007;
    localparam logic [127:0] S1  = 128'h4072da1240f930f7d3c8cf8b9322042e;
    localparam logic [127:0] CT1 = 128'hd225406f484809186cb5d86be4098445;
    localparam logic [127:0] K2  = 128'h1209239bbbe23cca9c3c8ccf138f54e0;
    localparam logic [127:0] S2  = 128'h110687e2636afdb84c12653d55f3bae1;
    localparam logic [127:0] CT2 = 128'h5867142e883b431b428fc33306a272de;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [N-1:0]      req_valid = '0;
    logic [N-1:0]      req_ready;
    logic [N*128-1:0]  req_key = '0;
    logic [N*128-1:0]  req_state = '0;
    logic [127:0]      core_key, core_state, rsp_data;
    logic [127:0]      core_out = '0;
    logic              rsp_valid, busy;
    logic              rsp_ready = 1'b0;
    logic [IW-1:0]     rsp_id;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    aes_core_arbiter #(.N_REQ(N), .CORE_LAT(LAT), .ID_W(IW)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_key(req_key), .req_state(req_state), .core_key(core_key),
        .core_state(core_state), .core_out(core_out), .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_id(rsp_id), .busy(busy)
    );

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // ---------------- AES-128 reference ----------------
    logic [7:0] sbox [256];

    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ a;
            a = xt(a);
        end
        return p;
    endfunction

    task automatic build_sbox();
        logic [7:0] inv;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            sbox[x] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
                      {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
        end
    endtask

    function automatic logic [127:0] aes_enc(input logic [127:0] key, input logic [127:0] pt);
        logic [31:0]  w [44];
        logic [7:0]   s [16];
        logic [7:0]   t [16];
        logic [31:0]  tmp;
        logic [7:0]   rc, a0, a1, a2, a3;
        logic [127:0] ct;
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        rc = 8'h01;
        for (int i = 4; i < 44; i++) begin
            tmp = w[i-1];
            if (i % 4 == 0) begin
                tmp = {tmp[23:0], tmp[31:24]};
                tmp = {sbox[tmp[31:24]], sbox[tmp[23:16]], sbox[tmp[15:8]], sbox[tmp[7:0]]} ^ {rc, 24'h0};
                rc  = xt(rc);
            end
            w[i] = w[i-4] ^ tmp;
        end
        for (int j = 0; j < 16; j++) s[j] = pt[127-8*j -: 8] ^ w[j/4][31-8*(j%4) -: 8];
        for (int r = 1; r <= 10; r++) begin
            for (int j = 0; j < 16; j++) t[j] = sbox[s[(j%4) + 4*(((j/4) + (j%4)) % 4)]];
            for (int c = 0; c < 4; c++) begin
                a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
                if (r != 10) begin
                    s[4*c]   = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
                    s[4*c+1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
                    s[4*c+2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
                    s[4*c+3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
                end else begin
                    s[4*c] = a0; s[4*c+1] = a1; s[4*c+2] = a2; s[4*c+3] = a3;
                end
            end
            for (int j = 0; j < 16; j++) s[j] = s[j] ^ w[4*r + j/4][31-8*(j%4) -: 8];
        end
        for (int j = 0; j < 16; j++) ct[127-8*j -: 8] = s[j];
        return ct;
    endfunction

    // Core stand-in: output is wrong until LAT-1 edges after the operands
    // settle, so an early capture returns garbage.
    logic [127:0] ck_prev = '0, cs_prev = '0, ct_cur = '0;
    int stab = 0;
    always @(posedge clk) begin
        #1;
        if (core_key !== ck_prev || core_state !== cs_prev) begin
            ck_prev = core_key;
            cs_prev = core_state;
            stab    = 0;
            ct_cur  = aes_enc(core_key, core_state);
        end else if (stab < 1000) begin
            stab++;
        end
        core_out = (stab >= LAT - 1) ? ct_cur : ~ct_cur;
    end

    // ---------------- transaction-level model ----------------
    function automatic int pick(input logic [N-1:0] v, input int p);
        int j;
        if (PRIO0 && v[0]) return 0;
        for (int k = 0; k < N; k++) begin
            j = (p + k) % N;
            if (v[j] && !(PRIO0 && j == 0)) return j;
        end
        return -1;
    endfunction

    function automatic int nxt(input int id);
        int n;
        n = (id + 1) % N;
        if (PRIO0 && n == 0) n = 1;
        return n;
    endfunction

    bit           chk_en = 1'b0;
    bit           m_act = 1'b0;
    int           m_age = 0, m_ptr = 0, m_id = 0, m_rid = 0;
    logic [127:0] m_ct = '0, m_ck = '0, m_cs = '0, m_rd = '0;

    int           cyc = 0;
    int           gq[$];
    int           rq_id[$];
    logic [127:0] rq_data[$];
    int           rdy_cnt[N];
    int           rv_cnt = 0, acc_cyc = 0, rise_cyc = 0;
    bit           rv_prev = 1'b0;
    logic [N-1:0] rdy_smp = '0;

    always @(posedge clk) cyc++;

    // Per-cycle compare against the model, then advance the model over the coming edge
    always @(negedge clk) begin
        int           g;
        logic [N-1:0] e_rdy;
        bit           e_rv;
        rdy_smp = req_ready;
        g = (!m_act && !rst) ? pick(req_valid, m_ptr) : -1;
        e_rdy = '0;
        if (g >= 0) e_rdy[g] = 1'b1;
        e_rv = m_act && (m_age >= LAT);
        if (chk_en) begin
            chk("req_ready",  128'(req_ready), 128'(e_rdy));
            chk("busy",       128'(busy),      128'(m_act));
            chk("rsp_valid",  128'(rsp_valid), 128'(e_rv));
            chk("rsp_data",   rsp_data,        m_rd);
            chk("rsp_id",     128'(rsp_id),    128'(m_rid));
            chk("core_key",   core_key,        m_ck);
            chk("core_state", core_state,      m_cs);
        end
        for (int i = 0; i < N; i++)
            if (req_ready[i] === 1'b1 && !rst) begin gq.push_back(i); rdy_cnt[i]++; end
        if (rsp_valid === 1'b1 && !rv_prev) rise_cyc = cyc;
        rv_prev = (rsp_valid === 1'b1);
        if (rsp_valid === 1'b1) rv_cnt++;
        if (rsp_valid === 1'b1 && rsp_ready && !rst) begin
            rq_id.push_back(int'(rsp_id));
            rq_data.push_back(rsp_data);
        end
        if (rst) begin
            m_act = 1'b0; m_age = 0; m_ptr = 0; m_rid = 0;
            m_ck = '0; m_cs = '0; m_rd = '0;
        end else if (m_act) begin
            if (e_rv && rsp_ready) begin
                m_act = 1'b0;
                m_ptr = nxt(m_id);
            end else begin
                m_age++;
                if (m_age == LAT) begin m_rd = m_ct; m_rid = m_id; end
            end
        end else if (g >= 0) begin
            m_act = 1'b1; m_age = 0; m_id = g;
            m_ck = req_key[g*128 +: 128];
            m_cs = req_state[g*128 +: 128];
            m_ct = aes_enc(m_ck, m_cs);
            acc_cyc = cyc;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic set_op(input int i, input logic [127:0] k, input logic [127:0] s);
        req_key[i*128 +: 128]   = k;
        req_state[i*128 +: 128] = s;
    endtask

    task automatic clear_logs();
        gq.delete(); rq_id.delete(); rq_data.delete();
        foreach (rdy_cnt[i]) rdy_cnt[i] = 0;
    endtask

    task automatic do_reset();
        rst = 1'b1; req_valid = '0;
        tick();
        chk("reset rsp_valid", 128'(rsp_valid), 128'(0));
        chk("reset busy",      128'(busy),      128'(0));
        chk("reset req_ready", 128'(req_ready), 128'(0));
        chk("reset rsp_data",  rsp_data,        128'(0));
        chk("reset rsp_id",    128'(rsp_id),    128'(0));
        tick();
        rst = 1'b0; chk_en = 1'b1;
    endtask

    task automatic wait_grants(input int n);
        int t = 0;
        while (gq.size() < n && t < 400) begin tick(); t++; end
        chk("grant count reached", 128'(gq.size() >= n), 128'(1));
    endtask

    task automatic wait_rsps(input int n);
        int t = 0;
        while (rq_id.size() < n && t < 400) begin tick(); t++; end
        chk("response count reached", 128'(rq_id.size() >= n), 128'(1));
    endtask

    task automatic wait_idle();
        int t = 0;
        while (busy && t < 100) begin tick(); t++; end
        chk("return to idle", 128'(busy), 128'(0));
    endtask

    // ---------------- scenarios ----------------
    task automatic t_single();
        do_reset(); clear_logs(); rsp_ready = 1'b1;
        chk("model pins vector 1", aes_enc(K1, S1), CT1);
        chk("model pins vector 2", aes_enc(K2, S2), CT2);
        set_op(2, K1, S1); req_valid[2] = 1'b1;
        wait_grants(1);
        req_valid[2] = 1'b0;
        wait_rsps(1);
        chk("single rsp_id",   128'(rq_id[0]), 128'(2));
        chk("single rsp_data", rq_data[0],     CT1);
        chk("single ready pulse count", 128'(rdy_cnt[2]), 128'(1));
        // accept sampled in cycle c, capture LAT edges after the accept edge,
        // so rsp_valid is first seen in cycle c+LAT+1
        chk("single rsp latency", 128'(rise_cyc - acc_cyc), 128'(LAT + 1));
        wait_idle();
    endtask

    task automatic t_all_four();
        int exp_g[5] = '{0, 1, 2, 3, 0};
        bit found = 1'b0;
        do_reset(); clear_logs(); rsp_ready = 1'b1;
        set_op(0, 128'h000102030405060708090a0b0c0d0e0f, 128'h00112233445566778899aabbccddeeff);
        set_op(1, K2, S2);
        set_op(2, K1, S1);
        set_op(3, 128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h3243f6a8885a308d313198a2e0370734);
        req_valid = '1;
        wait_grants(5);
        for (int k = 0; k < 5; k++) chk($sformatf("rr order[%0d]", k), 128'(gq[k]), 128'(exp_g[k]));
        req_valid = '0;
        wait_idle();
        for (int k = 0; k < rq_id.size(); k++)
            if (!found && rq_id[k] == 1) begin
                found = 1'b1;
                chk("vector 2 ciphertext", rq_data[k], CT2);
            end
        chk("vector 2 response seen", 128'(found), 128'(1));
    endtask

    task automatic t_backpressure();
        logic [127:0] d0;
        logic [IW-1:0] i0;
        int n0, t = 0;
        do_reset(); clear_logs(); rsp_ready = 1'b0;
        req_valid = '1;
        while (!rsp_valid && t < 100) begin tick(); t++; end
        chk("bp rsp_valid reached", 128'(rsp_valid), 128'(1));
        d0 = rsp_data; i0 = rsp_id; n0 = gq.size();
        chk("bp first id", 128'(i0), 128'(0));
        chk("bp first data", d0, aes_enc(req_key[127:0], req_state[127:0]));
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("bp rsp_valid held", 128'(rsp_valid), 128'(1));
            chk("bp rsp_data held",  rsp_data,        d0);
            chk("bp rsp_id held",    128'(rsp_id),    128'(i0));
            chk("bp busy",           128'(busy),      128'(1));
        end
        chk("bp no new grant", 128'(gq.size()), 128'(n0));
        req_valid = '0; rsp_ready = 1'b1;
        wait_idle();
    endtask

    task automatic t_reset_fairness();
        int exp_g[4] = '{3, 1, 3, 1};
        do_reset(); clear_logs(); rsp_ready = 1'b1;
        req_valid = 4'b0100;
        wait_grants(1); req_valid = '0;
        wait_rsps(1); wait_idle();
        clear_logs();
        req_valid = 4'b1000;
        wait_grants(1);
        req_valid = '0; rv_cnt = 0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        clear_logs();
        req_valid = 4'b1010;
        wait_grants(1);
        chk("post-reset first grant", 128'(gq[0]), 128'(1));
        chk("aborted op no rsp_valid", 128'(rv_cnt), 128'(0));
        wait_grants(5);
        for (int k = 0; k < 4; k++) chk($sformatf("fair order[%0d]", k), 128'(gq[k+1]), 128'(exp_g[k]));
        chk("first response after reset is port 1", 128'(rq_id[0]), 128'(1));
        req_valid = '0;
        wait_idle();
    endtask

    task automatic t_prio();
        int exp_g[3];
        exp_g = PRIO0 ? '{0, 0, 0} : '{0, 2, 0};
        do_reset(); clear_logs(); rsp_ready = 1'b1;
        req_valid = 4'b0101;
        wait_grants(3);
        req_valid[0] = 1'b0;
        for (int k = 0; k < 3; k++) chk($sformatf("prio order[%0d]", k), 128'(gq[k]), 128'(exp_g[k]));
        wait_grants(4);
        chk("port 2 after port 0 drops", 128'(gq[3]), 128'(2));
        req_valid = '0;
        wait_idle();
    endtask

    task automatic t_random();
        do_reset(); clear_logs();
        for (int c = 0; c < 1500; c++) begin
            tick();
            rst       = ($urandom_range(0, 99) == 0);
            rsp_ready = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < N; i++) begin
                if (req_valid[i] && !rdy_smp[i]) begin
                    if ($urandom_range(0, 15) == 0) req_valid[i] = 1'b0;
                end else if ($urandom_range(0, 1) == 1) begin
                    req_valid[i] = 1'b1;
                    set_op(i, {$urandom, $urandom, $urandom, $urandom},
                              {$urandom, $urandom, $urandom, $urandom});
                end else begin
                    req_valid[i] = 1'b0;
                end
            end
        end
        rst = 1'b0; req_valid = '0; rsp_ready = 1'b1;
        wait_idle();
        chk("random phase made progress", 128'(rq_id.size() > 50), 128'(1));
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, tests %0d", n_tests);
        $fatal(1);
    end

    initial begin
        build_sbox();
        t_single();
        t_all_four();
        t_backpressure();
        t_reset_fairness();
        t_prio();
        t_random();
        repeat (3) tick();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
